shift_sequencer: RTL and testbench

- Multi-bit shift controller wrapped around the existing single-step `shifter` datapath (ports in[15:0], shift[1:0], sout[15:0]; codes 00 pass, 01 LSL1, 10 LSR1, 11 ASR1).
- Accepts one shift request of 0..15 positions and iterates the shifter one bit per clock.
- Returns the result with a done pulse, giving the Simple RISC Machine datapath variable-amount shifts without a barrel shifter.

---
 rtl/shift_sequencer_if.sv | 27 ++
 rtl/shift_sequencer.sv | 117 +++++++++++
 tb/tb_shift_sequencer.sv | 180 ++++++++++++++++++
 3 files changed

// File: rtl/shift_sequencer_if.sv
// Request/response bundle between a shift requester and shift_sequencer.
// Handshake: a request (start with op/amt/value) is taken only on a rising clk edge where ready=1;
// done is a one-cycle pulse, and result stays valid from done until the next accepted request.
interface shift_sequencer_if #(
    parameter int W     = 16,
    parameter int AMT_W = 4
);
    logic             start;
    logic [1:0]       op;
    logic [AMT_W-1:0] amt;
    logic [W-1:0]     value;
    logic             ready;
    logic             busy;
    logic             done;
    logic [W-1:0]     result;
    logic [1:0]       state;

    modport master (
        output start, op, amt, value,
        input  ready, busy, done, result, state
    );

    modport slave (
        input  start, op, amt, value,
        output ready, busy, done, result, state
    );
endinterface

// File: rtl/shift_sequencer.sv
// Multi-bit shift controller iterating the single-step shifter once per clock.
// Optional feature: define SHSEQ_ROR_EN to turn op 00 into rotate-right.
module shifter #(
    parameter int W = 16
) (
    input  logic [W-1:0] in,
    input  logic [1:0]   shift,
    output logic [W-1:0] sout
);
    always_comb begin
        case (shift)
            2'b01:   sout = {in[W-2:0], 1'b0};
            2'b10:   sout = {1'b0, in[W-1:1]};
            2'b11:   sout = {in[W-1], in[W-1:1]};
            default: sout = in;
        endcase
    end
endmodule

module shift_sequencer #(
    parameter int W     = 16,
    parameter int AMT_W = 4
) (
    input  logic          clk,
    input  logic          reset,
    shift_sequencer_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state, state_nx;
    logic [W-1:0]     acc, acc_nx;
    logic [W-1:0]     result_r, result_nx;
    logic [AMT_W-1:0] cnt, cnt_nx;
    logic [1:0]       op_r, op_nx;
    logic [1:0]       sh_code;
    logic [W-1:0]     sout;
    logic [W-1:0]     step;

    shifter #(.W(W)) u_shifter (
        .in    (acc),
        .shift (sh_code),
        .sout  (sout)
    );

`ifdef SHSEQ_ROR_EN
    // Rotate reuses the LSR1 path and feeds the outgoing LSB back into the MSB.
    always_comb begin
        sh_code = (op_r == 2'b00) ? 2'b10 : op_r;
        step    = (op_r == 2'b00) ? {acc[0], sout[W-2:0]} : sout;
    end
`else
    always_comb begin
        sh_code = op_r;
        step    = sout;
    end
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            acc      <= '0;
            cnt      <= '0;
            op_r     <= '0;
            result_r <= '0;
        end else begin
            state    <= state_nx;
            acc      <= acc_nx;
            cnt      <= cnt_nx;
            op_r     <= op_nx;
            result_r <= result_nx;
        end
    end

    // result_r is loaded on the edge entering DONE so it already equals acc during the done pulse.
    always_comb begin
        state_nx  = state;
        acc_nx    = acc;
        cnt_nx    = cnt;
        op_nx     = op_r;
        result_nx = result_r;
        case (state)
            IDLE: begin
                if (bus.start) begin
                    acc_nx = bus.value;
                    op_nx  = bus.op;
                    cnt_nx = bus.amt;
                    if (bus.amt == '0) begin
                        state_nx  = DONE;
                        result_nx = bus.value;
                    end else begin
                        state_nx = RUN;
                    end
                end
            end
            RUN: begin
                acc_nx = step;
                cnt_nx = cnt - 1'b1;
                if (cnt == AMT_W'(1)) begin
                    state_nx  = DONE;
                    result_nx = step;
                end
            end
            DONE: state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    assign bus.ready  = (state == IDLE);
    assign bus.busy   = (state == RUN);
    assign bus.done   = (state == DONE);
    assign bus.result = result_r;
    assign bus.state  = state;
endmodule

// File: tb/tb_shift_sequencer.sv
// Directed plus randomized bench for shift_sequencer against a behavioural shift model.
module tb_shift_sequencer;
    logic clk;
    logic reset;
    int   checks;
    int   errors;
    logic [15:0] exp_q[$];

    shift_sequencer_if #(.W(16), .AMT_W(4)) bus ();

    shift_sequencer #(.W(16), .AMT_W(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Shift rules stated arithmetically over the whole amount at once.
    function automatic logic [15:0] model(input logic [15:0] v, input logic [1:0] o, input int a);
        logic [31:0] w;
        case (o)
            2'b01: model = v << a;
            2'b10: model = v >> a;
            2'b11: model = 16'($signed(v) >>> a);
            default: begin
`ifdef SHSEQ_ROR_EN
                w     = {v, v} >> a;
                model = w[15:0];
`else
                w     = {16'h0, v};
                model = w[15:0];
`endif
            end
        endcase
    endfunction

    // Issue one request; with poke set, a conflicting request is held on the bus while busy.
    task automatic run_op(input logic [15:0] v, input logic [1:0] o, input int a, input bit poke);
        int busy_n;
        int guard;
        logic [15:0] expected;
        chk("ready_before", bus.ready, 1);
        bus.value = v;
        bus.op    = o;
        bus.amt   = 4'(a);
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        exp_q.push_back(model(v, o, a));
        busy_n = 0;
        guard  = 0;
        while (bus.done !== 1'b1 && guard < 40) begin
            chk("onehot", 32'($countones({bus.ready, bus.busy, bus.done})), 1);
            if (bus.busy === 1'b1) busy_n++;
            if (poke) begin
                bus.start = 1'b1;
                bus.value = 16'hFFFF;
                bus.amt   = 4'd1;
            end
            tick();
            guard++;
        end
        bus.start = 1'b0;
        chk("done_timeout", (guard < 40), 1);
        chk("busy_cycles", busy_n, a);
        chk("done_latency", guard, a);
        chk("done_exclusive", {bus.ready, bus.busy}, 0);
        expected = exp_q.pop_front();
        chk("result_at_done", bus.result, expected);
        tick();
        chk("done_one_pulse", bus.done, 0);
        chk("ready_after", bus.ready, 1);
        chk("result_hold", bus.result, expected);
    endtask

    initial begin
        checks    = 0;
        errors    = 0;
        bus.start = 1'b0;
        bus.op    = 2'b00;
        bus.amt   = 4'd0;
        bus.value = 16'h0;
        reset     = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        chk("rst_ready", bus.ready, 1);
        chk("rst_busy", bus.busy, 0);
        chk("rst_done", bus.done, 0);
        chk("rst_result", bus.result, 0);
        chk("rst_state", bus.state, 0);

        run_op(16'h00F0, 2'b01, 4, 1'b0);
        chk("tp_lsl4", bus.result, 16'h0F00);
        run_op(16'h80F0, 2'b11, 3, 1'b0);
        chk("tp_asr3", bus.result, 16'hF01E);
        run_op(16'h80F0, 2'b10, 15, 1'b0);
        chk("tp_lsr15", bus.result, 16'h0001);
        run_op(16'h1234, 2'b01, 0, 1'b0);
        chk("tp_amt0", bus.result, 16'h1234);
        run_op(16'h8001, 2'b11, 15, 1'b0);
        chk("tp_asr15_neg", bus.result, 16'hFFFF);

        run_op(16'h00FF, 2'b01, 8, 1'b1);
        chk("tp_ignore_busy", bus.result, 16'hFF00);
        run_op(16'hFFFF, 2'b01, 1, 1'b0);
        chk("tp_represented", bus.result, 16'hFFFE);

        // Reset on the third RUN cycle aborts the operation.
        bus.value = 16'hABCD;
        bus.op    = 2'b10;
        bus.amt   = 4'd10;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        tick();
        tick();
        chk("abort_busy", bus.busy, 1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("abort_ready", bus.ready, 1);
        chk("abort_busy_low", bus.busy, 0);
        chk("abort_done", bus.done, 0);
        chk("abort_result", bus.result, 0);
        for (int i = 0; i < 14; i++) begin
            tick();
            chk("abort_no_done", bus.done, 0);
        end

        // start coinciding with reset is dropped.
        bus.value = 16'h5555;
        bus.op    = 2'b01;
        bus.amt   = 4'd2;
        bus.start = 1'b1;
        reset     = 1'b1;
        tick();
        reset     = 1'b0;
        bus.start = 1'b0;
        chk("rst_start_ready", bus.ready, 1);
        tick();
        chk("rst_start_idle", bus.ready, 1);
        chk("rst_start_result", bus.result, 0);

        run_op(16'h0001, 2'b00, 1, 1'b0);
`ifdef SHSEQ_ROR_EN
        chk("tp_op00_a", bus.result, 16'h8000);
`else
        chk("tp_op00_a", bus.result, 16'h0001);
`endif
        run_op(16'h00F1, 2'b00, 4, 1'b0);
`ifdef SHSEQ_ROR_EN
        chk("tp_op00_b", bus.result, 16'h100F);
`else
        chk("tp_op00_b", bus.result, 16'h00F1);
`endif

        for (int n = 0; n < 24; n++) begin
            run_op(16'($urandom), 2'($urandom_range(0, 3)), $urandom_range(0, 15), 1'($urandom_range(0, 1)));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
